// File: rtl/transmit_beamform_if.sv
// Control/drive bundle for the transmit beamformer:
// burst request and delays in, transducer drive and status out.
interface transmit_beamform_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int DELAY_WIDTH  = 12,
    parameter int CYCLES_WIDTH = 8
);
    logic                                     start;
    logic [NUM_CHANNELS-1:0][DELAY_WIDTH-1:0] delay_in;
    logic [CYCLES_WIDTH-1:0]                  num_cycles_in;
    logic [NUM_CHANNELS-1:0]                  tx_out;
    logic                                     busy;
    logic                                     done;

    modport master (
        output start, delay_in, num_cycles_in,
        input  tx_out, busy, done
    );

    modport slave (
        input  start, delay_in, num_cycles_in,
        output tx_out, busy, done
    );
endinterface

// File: rtl/transmit_beamform.sv
// Steered square-wave burst generator for the transmit array.
// Each channel starts its burst after its own delay from the start strobe.
module transmit_beamform #(
    parameter int NUM_CHANNELS = 4,
    parameter int HALF_PERIOD  = 1250,
    parameter int DELAY_WIDTH  = 12,
    parameter int CYCLES_WIDTH = 8,
    parameter int TIMER_WIDTH  = 24
) (
    input  logic                clk,
    input  logic                rst,
    transmit_beamform_if.slave  bus
);
    localparam int HPW = $clog2(HALF_PERIOD);
    localparam int HCW = CYCLES_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FIRE, FINISH} state_t;

    state_t                   state, state_n;
    logic [TIMER_WIDTH-1:0]   timer, timer_n;
    logic [TIMER_WIDTH-1:0]   t_end, t_end_n;
    logic [TIMER_WIDTH-1:0]   t_end_in, t_nxt;
    logic [DELAY_WIDTH-1:0]   d_q [NUM_CHANNELS];
    logic [DELAY_WIDTH-1:0]   d_n [NUM_CHANNELS];
    logic [DELAY_WIDTH-1:0]   dmax;
    logic [CYCLES_WIDTH-1:0]  n_q, n_n;
    logic [HPW-1:0]           hp_q [NUM_CHANNELS];
    logic [HPW-1:0]           hp_n [NUM_CHANNELS];
    logic [HCW-1:0]           hc_q [NUM_CHANNELS];
    logic [HCW-1:0]           hc_n [NUM_CHANNELS];
    logic [HCW-1:0]           last_hc;
    logic [NUM_CHANNELS-1:0]  run_q, run_n;
    logic [NUM_CHANNELS-1:0]  tx_q, tx_n;
    logic [NUM_CHANNELS-1:0]  load;
    logic                     busy_q, busy_n;
    logic                     done_q, done_n;
    logic                     step, clear;

    always_comb begin
        dmax = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (bus.delay_in[i] > dmax) dmax = bus.delay_in[i];
        t_end_in = TIMER_WIDTH'(dmax)
                 + TIMER_WIDTH'(2 * HALF_PERIOD)
                 * TIMER_WIDTH'(bus.num_cycles_in);
        t_nxt = timer + TIMER_WIDTH'(1);
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        t_end_n = t_end;
        n_n     = n_q;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        step    = 1'b0;
        clear   = 1'b1;
        load    = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) d_n[i] = d_q[i];
        unique case (state)
            IDLE, FINISH: begin
                state_n = IDLE;
                timer_n = '0;
                if (bus.start) begin
                    t_end_n = t_end_in;
                    n_n     = bus.num_cycles_in;
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        d_n[i]  = bus.delay_in[i];
                        load[i] = (bus.delay_in[i] == '0) &&
                                  (bus.num_cycles_in != '0);
                    end
                    if (t_end_in == '0) begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                        load    = '0;
                    end else begin
                        state_n = FIRE;
                        busy_n  = 1'b1;
                        clear   = 1'b0;
                    end
                end
            end
            FIRE: begin
                timer_n = t_nxt;
                if (t_nxt == t_end) begin
                    state_n = FINISH;
                    done_n  = 1'b1;
                end else begin
                    busy_n = 1'b1;
                    clear  = 1'b0;
                    step   = 1'b1;
                    for (int i = 0; i < NUM_CHANNELS; i++)
                        load[i] = (t_nxt == TIMER_WIDTH'(d_q[i])) &&
                                  (n_q != '0);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Burst ends after 2N half periods: last half-cycle index is 2N-1.
    assign last_hc = {n_q, 1'b0} - HCW'(1);

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            run_n[i] = run_q[i];
            tx_n[i]  = tx_q[i];
            hp_n[i]  = hp_q[i];
            hc_n[i]  = hc_q[i];
            if (clear) begin
                run_n[i] = 1'b0;
                tx_n[i]  = 1'b0;
                hp_n[i]  = '0;
                hc_n[i]  = '0;
            end else if (load[i]) begin
                run_n[i] = 1'b1;
                tx_n[i]  = 1'b1;
                hp_n[i]  = '0;
                hc_n[i]  = '0;
            end else if (step && run_q[i]) begin
                if (hp_q[i] == HPW'(HALF_PERIOD - 1)) begin
                    hp_n[i] = '0;
                    if (hc_q[i] == last_hc) begin
                        run_n[i] = 1'b0;
                        tx_n[i]  = 1'b0;
                    end else begin
                        hc_n[i] = hc_q[i] + HCW'(1);
                        tx_n[i] = ~tx_q[i];
                    end
                end else begin
                    hp_n[i] = hp_q[i] + HPW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            t_end  <= '0;
            n_q    <= '0;
            run_q  <= '0;
            tx_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                d_q[i]  <= '0;
                hp_q[i] <= '0;
                hc_q[i] <= '0;
            end
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            t_end  <= t_end_n;
            n_q    <= n_n;
            run_q  <= run_n;
            tx_q   <= tx_n;
            busy_q <= busy_n;
            done_q <= done_n;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                d_q[i]  <= d_n[i];
                hp_q[i] <= hp_n[i];
                hc_q[i] <= hc_n[i];
            end
        end
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
